mod_updown_counter: RTL and testbench

//   Loadable modulo-N up/down counter assembled from async-clear D flip-flop stages.

---
 rtl/mod_updown_counter.sv | 82 ++++++++
 tb/tb_mod_updown_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Loadable modulo-MODULO up/down counter with combinational terminal count and registered wrap pulse.
// Define COUNTER_SATURATE_EN to make the count stop at its limits instead of wrapping.
module mod_updown_counter #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned MODULO = 10
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] cur;
   logic             wrap_q, wrap_d;
   logic             at_top, at_bot;
`ifdef COUNTER_SATURATE_EN
   logic             pinned_q, pinned_d;
`endif

   always_comb begin
      // An out-of-range value is stepped as if it were the top of the range.
      cur     = (32'(count_q) >= MODULO) ? LAST : count_q;
      at_top  = (cur == LAST);
      at_bot  = (cur == '0);
      count_d = count_q;
      wrap_d  = 1'b0;
`ifdef COUNTER_SATURATE_EN
      pinned_d = 1'b0;
`endif
      if (load) begin
         count_d = (32'(load_val) >= MODULO) ? LAST : load_val;
      end else if (en) begin
`ifdef COUNTER_SATURATE_EN
         // Pulse only on the first blocked step; stay quiet while pinned.
         if ((up && at_top) || (!up && at_bot)) begin
            count_d  = up ? LAST : '0;
            pinned_d = 1'b1;
            wrap_d   = ~pinned_q;
         end else begin
            count_d = up ? cur + WIDTH'(1) : cur - WIDTH'(1);
         end
`else
         if (up) begin
            count_d = at_top ? '0 : cur + WIDTH'(1);
            wrap_d  = at_top;
         end else begin
            count_d = at_bot ? LAST : cur - WIDTH'(1);
            wrap_d  = at_bot;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count_q  <= '0;
         wrap_q   <= 1'b0;
`ifdef COUNTER_SATURATE_EN
         pinned_q <= 1'b0;
`endif
      end else begin
         count_q  <= count_d;
         wrap_q   <= wrap_d;
`ifdef COUNTER_SATURATE_EN
         pinned_q <= pinned_d;
`endif
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign tc    = en & ~load & ((up & (count_q == LAST)) | (~up & (count_q == '0)));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=4, MODULO=10): vector table,
// hand sequences for reset/direction/limit corners, and random stimulus against a reference model.
module tb_mod_updown_counter;
   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         clear_n = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] count;
   logic         tc;
   logic         wrap;

   mod_updown_counter #(.WIDTH(W), .MODULO(M)) dut (
      .clk(clk), .clear_n(clear_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int m_count  = 0;
   bit m_wrap   = 0;
   bit m_pinned = 0;

   typedef struct {
      bit e; bit u; bit l; int lv;
      bit etc; int ecount; bit ewrap;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_tc(input bit e, input bit u, input bit l);
      return e && !l && (u ? (m_count == M - 1) : (m_count == 0));
   endfunction

   task automatic model_edge(input bit e, input bit u, input bit l, input int lv);
      bit attempt;
      if (l) begin
         m_count  = (lv >= M) ? M - 1 : lv;
         m_wrap   = 0;
         m_pinned = 0;
      end else if (e) begin
         attempt = u ? (m_count >= M - 1) : (m_count == 0);
`ifdef COUNTER_SATURATE_EN
         if (attempt) begin
            m_count  = u ? M - 1 : 0;
            m_wrap   = !m_pinned;
            m_pinned = 1;
         end else begin
            m_count  = u ? m_count + 1 : m_count - 1;
            m_wrap   = 0;
            m_pinned = 0;
         end
`else
         m_count = u ? (m_count + 1) % M : (m_count + M - 1) % M;
         m_wrap  = attempt;
`endif
      end else begin
         m_wrap   = 0;
         m_pinned = 0;
      end
   endtask

   task automatic drive(input bit e, input bit u, input bit l, input int lv);
      en = e; up = u; load = l; load_val = W'(lv);
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic step(input bit e, input bit u, input bit l, input int lv, input string nm);
      drive(e, u, l, lv);
      #1;
      chk({nm, " tc"}, int'(tc), int'(m_tc(e, u, l)));
      model_edge(e, u, l, lv);
      @(posedge clk); #1;
      chk({nm, " count"}, int'(count), m_count);
      chk({nm, " wrap"}, int'(wrap), int'(m_wrap));
   endtask

   initial begin
      int exp_seq[12];
      int exp5[12];
      int exp6[3];
      int wrp6[3];
      bit u5;

      // Reset state while clear_n is held low
      #2;
      chk("reset count", int'(count), 0);
      chk("reset wrap", int'(wrap), 0);
      #10 clear_n = 1'b1;
      @(posedge clk); #1;
      chk("post-release count", int'(count), 0);

`ifndef COUNTER_SATURATE_EN
      tbl[0] = '{1, 1, 1, 7,  0, 7, 0};  // load beats en
      tbl[1] = '{1, 1, 1, 12, 0, 9, 0};  // load clamps
      tbl[2] = '{1, 1, 0, 0,  1, 0, 1};  // 9 -> 0 wraps
      tbl[3] = '{1, 0, 0, 0,  1, 9, 1};  // 0 -> 9 wraps
      tbl[4] = '{1, 0, 0, 0,  0, 8, 0};
      tbl[5] = '{0, 0, 0, 0,  0, 8, 0};  // hold
      tbl[6] = '{0, 1, 1, 15, 0, 9, 0};  // load clamps with en low
      tbl[7] = '{0, 1, 0, 0,  0, 9, 0};  // tc needs en
      tbl[8] = '{1, 1, 1, 3,  0, 3, 0};
      tbl[9] = '{1, 0, 1, 0,  0, 0, 0};
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv);
         #1;
         chk($sformatf("tbl%0d tc", i), int'(tc), int'(tbl[i].etc));
         model_edge(tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d count", i), int'(count), tbl[i].ecount);
         chk($sformatf("tbl%0d wrap", i), int'(wrap), int'(tbl[i].ewrap));
      end

      // Count up 12 edges from 0
      exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 0, 0, $sformatf("up%0d", i));
         chk($sformatf("up%0d lit", i), int'(count), exp_seq[i]);
         chk($sformatf("up%0d wlit", i), int'(wrap), (i == 9) ? 1 : 0);
      end

      // Count down from 0
      step(1, 0, 1, 0, "dn load");
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, $sformatf("dn%0d", i));
         chk($sformatf("dn%0d lit", i), int'(count), 9 - i);
         chk($sformatf("dn%0d wlit", i), int'(wrap), (i == 0) ? 1 : 0);
      end
`endif

      // Asynchronous clear between edges, with a wrap pulse showing and en pending
      step(0, 1, 1, 9, "pre-clr load");
      step(1, 1, 0, 0, "pre-clr step");
      drive(1, 1, 0, 0);
      #3 clear_n = 1'b0;
      #1;
      chk("async clr count", int'(count), 0);
      chk("async clr wrap", int'(wrap), 0);
      @(posedge clk); #1;
      chk("clr held count", int'(count), 0);
      clear_n  = 1'b1;
      m_count  = 0;
      m_wrap   = 0;
      m_pinned = 0;
      step(1, 1, 0, 0, "clr release");
      chk("clr release lit", int'(count), 1);

      // Direction toggled every 3 edges from 5
      step(0, 0, 1, 5, "tog load");
      exp5 = '{6, 7, 8, 7, 6, 5, 6, 7, 8, 7, 6, 5};
      for (int i = 0; i < 12; i++) begin
         u5 = ((i / 3) % 2) == 0;
         step(1, u5, 0, 0, $sformatf("tog%0d", i));
         chk($sformatf("tog%0d lit", i), int'(count), exp5[i]);
      end

      // Upper limit from 8
`ifdef COUNTER_SATURATE_EN
      exp6 = '{9, 9, 9};
`else
      exp6 = '{9, 0, 1};
`endif
      wrp6 = '{0, 1, 0};
      step(0, 1, 1, 8, "lim load");
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0, $sformatf("lim%0d", i));
         chk($sformatf("lim%0d lit", i), int'(count), exp6[i]);
         chk($sformatf("lim%0d wlit", i), int'(wrap), wrp6[i]);
      end

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
